// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the board UART path (receiver today, transmitter and
// RX-side top later): frame geometry, default bit period, idle line level and
// the receive FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

  // Frame geometry: 8 data bits, no parity, 1 stop bit.
  localparam int DATA_BITS = 8;

  // Default clock cycles per bit: 100 MHz / 115200 baud.
  localparam int BAUD_PER_DEF = 868;

  // A UART line rests high between frames.
  localparam logic LINE_IDLE = 1'b1;

  // Receive FSM state encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef logic [1:0]           rx_state_t;
  typedef logic [DATA_BITS-1:0] rx_byte_t;

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for an asynchronous input, followed by one more flop
// holding the previous synchronized value so the caller can detect edges.
// All flops reset to the idle line level so a released reset never looks like
// a falling edge.
// Ports:
//   i_clk    in   clock of the receiving domain
//   i_rst_n  in   asynchronous active-low reset
//   i_async  in   raw asynchronous input
//   o_sync   out  synchronized input
//   o_prev   out  synchronized input delayed by one clock
// -----------------------------------------------------------------------------
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_prev
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Metastability chain plus the edge-detect history flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= LINE_IDLE;
      r_sync <= LINE_IDLE;
      r_prev <= LINE_IDLE;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_prev = r_prev;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver. Detects the start edge on the synchronized line, samples
// the start bit at mid-bit, then data bits LSB first and the stop bit one bit
// period apart. Completed bytes are offered on a valid/ready interface.
// Ports:
//   clk_100MHz    in   system clock
//   nrst_i        in   asynchronous active-low reset
//   uartrx_ser_i  in   serial line, idle high, asynchronous
//   rx_data_o     out  received byte
//   rx_valid_o    out  rx_data_o holds an unconsumed byte
//   rx_ready_i    in   consumer takes the byte when high with rx_valid_o
//   frame_err_o   out  one-cycle pulse: stop bit sampled low
//   overrun_o     out  sticky: a completed byte was dropped (output full)
//   err_clr_i     in   clears overrun_o (a coincident new overrun wins)
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_PER = BAUD_PER_DEF
)(
  input  logic                 clk_100MHz,
  input  logic                 nrst_i,
  input  logic                 uartrx_ser_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  input  logic                 err_clr_i
);

  localparam int CW = $clog2(BAUD_PER);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_PER / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(BAUD_PER - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  logic      w_rxs;
  logic      w_prev;
  logic      w_fall;

  rx_state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  rx_byte_t  r_shift;
  logic      r_done;    // one-cycle strobe: good stop bit just sampled
  logic      r_ferr;
  rx_byte_t  r_data;
  logic      r_valid;
  logic      r_ovr;

  uart_rx_sync u_sync (
    .i_clk   (clk_100MHz),
    .i_rst_n (nrst_i),
    .i_async (uartrx_ser_i),
    .o_sync  (w_rxs),
    .o_prev  (w_prev)
  );

  // Needs a high-to-low transition, so a held-low break cannot retrigger.
  assign w_fall = w_prev & ~w_rxs;

  // Frame FSM: start detect, mid-bit sampling, shift register, stop check.
  always_ff @(posedge clk_100MHz or negedge nrst_i) begin
    if (!nrst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= 3'd0;
      r_shift <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ferr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_state <= ST_START;
            r_cnt   <= '0;
          end
        end
        ST_START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt <= '0;
            // A line back high at mid start bit was only a glitch.
            if (w_rxs == 1'b0) begin
              r_state <= ST_DATA;
              r_bit   <= 3'd0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (r_cnt == FULL_LAST) begin
            r_cnt   <= '0;
            r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
            if (r_bit == LAST_BIT) begin
              r_state <= ST_STOP;
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_STOP: begin
          if (r_cnt == FULL_LAST) begin
            // Leave mid stop bit so a start edge right after it is caught.
            r_cnt   <= '0;
            r_state <= ST_IDLE;
            if (w_rxs == 1'b1) begin
              r_done <= 1'b1;
            end else begin
              r_ferr <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Output holding register and valid/ready handshake.
  always_ff @(posedge clk_100MHz or negedge nrst_i) begin
    if (!nrst_i) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (r_done && (!r_valid || rx_ready_i)) begin
      // Slot free, or emptied by a transfer this very edge.
      r_data  <= r_shift;
      r_valid <= 1'b1;
    end else if (r_valid && rx_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  // Sticky overrun flag; setting takes priority over a coincident clear.
  always_ff @(posedge clk_100MHz or negedge nrst_i) begin
    if (!nrst_i) begin
      r_ovr <= 1'b0;
    end else if (r_done && r_valid && !rx_ready_i) begin
      r_ovr <= 1'b1;
    end else if (err_clr_i) begin
      r_ovr <= 1'b0;
    end
  end

  assign rx_data_o   = r_data;
  assign rx_valid_o  = r_valid;
  assign frame_err_o = r_ferr;
  assign overrun_o   = r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx with BAUD_PER=10. Frames are driven one bit per
// 10 clocks starting on a falling clock edge; the start edge is then acted on
// at the 3rd rising edge (D), the stop bit is sampled at rising edge D+95 and
// rx_valid_o rises at D+96. Observed on falling edges, that is negedge 98 and
// 99 counted from the start of the frame.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  logic       clk_100MHz = 1'b0;
  logic       nrst_i;
  logic       ser;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       ready;
  logic       frame_err_o;
  logic       overrun_o;
  logic       clr;

  int n_chk  = 0;
  int n_fail = 0;

  logic       v98, f98, v99, f99, o99;
  logic [7:0] d99;
  int         fcnt, vcnt;
  logic [7:0] rst_d;
  logic       rst_v, rst_o, rst_f;

  uart_rx #(.BAUD_PER(10)) dut (
    .clk_100MHz   (clk_100MHz),
    .nrst_i       (nrst_i),
    .uartrx_ser_i (ser),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (ready),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o),
    .err_clr_i    (clr)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_100MHz);
  endtask

  // Drive one 100-cycle frame, capturing outputs around the stop sample.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input logic rdy98, input logic clr98, input int rst_at);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    fcnt = 0;
    vcnt = 0;
    for (int k = 0; k < 100; k++) begin
      ser = bits[k / 10];
      if (k == rst_at) begin
        nrst_i = 1'b0;
        #1;
        rst_d = rx_data_o;
        rst_v = rx_valid_o;
        rst_o = overrun_o;
        rst_f = frame_err_o;
      end
      if (rst_at >= 0 && k == rst_at + 2) nrst_i = 1'b1;
      if (k == 98) begin
        v98 = rx_valid_o;
        f98 = frame_err_o;
        if (rdy98) ready = 1'b1;
        if (clr98) clr = 1'b1;
      end
      if (k == 99) begin
        v99 = rx_valid_o;
        f99 = frame_err_o;
        d99 = rx_data_o;
        o99 = overrun_o;
        clr = 1'b0;
      end
      if (frame_err_o) fcnt++;
      if (rx_valid_o) vcnt++;
      @(negedge clk_100MHz);
    end
    ser = 1'b1;
  endtask

  initial begin
    nrst_i = 1'b0;
    ser    = 1'b1;
    ready  = 1'b0;
    clr    = 1'b0;
    idle(2);
    chk8("rst_data", rx_data_o, 8'h00);
    chk1("rst_valid", rx_valid_o, 1'b0);
    chk1("rst_ferr", frame_err_o, 1'b0);
    chk1("rst_ovr", overrun_o, 1'b0);
    nrst_i = 1'b1;
    idle(5);

    // 0xA5 with precise valid timing, held until consumed.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, -1);
    chk1("a5_v_d95", v98, 1'b0);
    chk1("a5_v_d96", v99, 1'b1);
    chk8("a5_data", d99, 8'hA5);
    chki("a5_ferr_cnt", fcnt, 0);
    idle(10);
    chk1("a5_hold_v", rx_valid_o, 1'b1);
    chk8("a5_hold_d", rx_data_o, 8'hA5);
    ready = 1'b1;
    idle(1);
    chk1("a5_taken", rx_valid_o, 1'b0);
    idle(2);
    chk1("ready_no_valid", rx_valid_o, 1'b0);
    chk1("ready_no_ovr", overrun_o, 1'b0);

    // Back-to-back frames with the consumer always ready.
    send_frame(8'h12, 1'b1, 1'b0, 1'b0, -1);
    chk8("b2b1_data", d99, 8'h12);
    chki("b2b1_vcnt", vcnt, 1);
    send_frame(8'h34, 1'b1, 1'b0, 1'b0, -1);
    chk8("b2b2_data", d99, 8'h34);
    chki("b2b2_vcnt", vcnt, 1);
    chki("b2b2_ferr", fcnt, 0);
    chk1("b2b_ovr", overrun_o, 1'b0);
    ready = 1'b0;
    idle(3);

    // 3-cycle low glitch is rejected at the start-bit check.
    ser = 1'b0;
    idle(3);
    ser = 1'b1;
    fcnt = 0;
    vcnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (frame_err_o) fcnt++;
      if (rx_valid_o) vcnt++;
      @(negedge clk_100MHz);
    end
    chki("glitch_valid", vcnt, 0);
    chki("glitch_ferr", fcnt, 0);

    // Bad stop bit, then a good frame.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1);
    chk1("ferr_at_stop", f98, 1'b1);
    chk1("ferr_gone", f99, 1'b0);
    chki("ferr_cnt", fcnt, 1);
    chk1("ferr_no_valid", v99, 1'b0);
    idle(10);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, -1);
    chk1("5a_valid", v99, 1'b1);
    chk8("5a_data", d99, 8'h5A);
    chki("5a_ferr", fcnt, 0);
    ready = 1'b1;
    idle(1);
    ready = 1'b0;
    chk1("5a_taken", rx_valid_o, 1'b0);

    // Overrun, clear, set-beats-clear, and completion coincident with ready.
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, -1);
    chk8("ovr_first", d99, 8'h11);
    idle(3);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, -1);
    chk8("ovr_kept", d99, 8'h11);
    chk1("ovr_set", o99, 1'b1);
    chk1("ovr_valid", v99, 1'b1);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    chk1("ovr_clr", overrun_o, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0, 1'b1, -1);
    chk1("ovr_set_wins", o99, 1'b1);
    chk8("ovr_kept2", d99, 8'h11);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    chk1("ovr_clr2", overrun_o, 1'b0);
    send_frame(8'h33, 1'b1, 1'b1, 1'b0, -1);
    chk8("coinc_data", d99, 8'h33);
    chk1("coinc_valid", v99, 1'b1);
    chk1("coinc_no_ovr", o99, 1'b0);
    ready = 1'b0;
    chk1("coinc_taken", rx_valid_o, 1'b0);

    // Reset during data bit 4, then recovery.
    send_frame(8'h66, 1'b1, 1'b0, 1'b0, -1);
    chk8("pre_rst_data", d99, 8'h66);
    idle(3);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 55);
    chk8("midrst_data", rst_d, 8'h00);
    chk1("midrst_valid", rst_v, 1'b0);
    chk1("midrst_ovr", rst_o, 1'b0);
    chk1("midrst_ferr", rst_f, 1'b0);
    chk1("after_rst_valid", rx_valid_o, 1'b0);
    idle(5);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, -1);
    chk1("81_valid", v99, 1'b1);
    chk8("81_data", d99, 8'h81);
    chk1("81_ovr", o99, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver that consumes the serial stream produced by top_print's uarttx_ser_o.
- Delivers received bytes on a valid/ready interface.
- Serves as the loopback checker in print-path benches and as the RX front end for a later command path on the board.
- Baud timing is a clock-count parameter matching the transmitter's BAUD_PER.

Parameters:
- BAUD_PER, 868, clk_100MHz cycles per bit (100 MHz / 115200); legal range >= 4; benches use 10.
- DATA_BITS, 8, data bits per frame; fixed at 8 for this revision.

Ports:
- clk_100MHz  in  1  system clock, 100 MHz
- nrst_i  in  1  reset, asynchronous, active-low
- uartrx_ser_i  in  1  serial line, idle high, asynchronous to clk_100MHz
- rx_data_o  out  8  received byte, LSB-first reassembled
- rx_valid_o  out  1  rx_data_o holds an unconsumed byte
- rx_ready_i  in  1  consumer accepts byte when high with rx_valid_o
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low
- overrun_o  out  1  sticky: a byte was dropped because the output was still full
- err_clr_i  in  1  clears overrun_o

Behaviour:
- Clock and reset: one clock, clk_100MHz. Reset is asynchronous, active-low on nrst_i.
- Reset values:
  - rx_data_o=0, rx_valid_o=0, frame_err_o=0, overrun_o=0.
  - Synchronizer flops=1 (idle).
  - FSM=IDLE; bit and baud counters=0.
- Input: 2-flop synchronizer, then one extra flop for edge detect. The synchronized line is "rxs". Detection occurs 2-3 cycles after the pad edge.
- IDLE:
  - rxs falling edge (prev 1, now 1->0) -> START, baud counter cleared.
  - A line held low continuously (break) never retriggers.
- START: at count BAUD_PER/2-1 (integer division), sample rxs.
  - 0 -> DATA, counter cleared, bit index 0.
  - 1 -> IDLE (glitch reject, no outputs change).
- DATA: every BAUD_PER cycles, sample rxs into shift register, LSB first.
  - After the bit index 7 sample -> STOP, counter cleared.
- STOP: after BAUD_PER cycles, sample rxs, then -> IDLE.
  - 1 -> frame complete.
  - 0 -> frame_err_o pulses high for exactly 1 cycle; data discarded, valid untouched.
- Sample points, relative to the detection cycle D:
  - start check at D+BAUD_PER/2
  - data bit i at D+BAUD_PER/2+(i+1)*BAUD_PER
  - stop at D+BAUD_PER/2+9*BAUD_PER
- Output register:
  - On frame complete, rx_data_o/rx_valid_o update on the next clock edge.
  - rx_valid_o rises 1 cycle after the stop sample.
- Handshake:
  - Transfer occurs at a clock edge where rx_valid_o&rx_ready_i.
  - rx_valid_o then falls unless a new byte completes the same cycle.
  - rx_data_o stays stable while rx_valid_o=1 and no transfer occurs.
- Boundary cases:
  - Complete while valid&!ready: new byte dropped, old byte retained, overrun_o set.
  - Complete while valid&ready: new byte loaded, rx_valid_o stays 1, no overrun.
  - Set overrun and err_clr_i in the same cycle: set wins.
  - rx_ready_i with rx_valid_o=0: ignored.
  - Reset mid-frame: immediate return to reset values; the next full frame after release is received correctly.
- Back-to-back frames: the receiver returns to IDLE at the stop sample (mid stop bit), so it accepts a start edge immediately following the stop bit.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding constants (IDLE, START, DATA, STOP)
  - DATA_BITS=8
  - default BAUD_PER=868
  - idle line level constant
- The future RX-side top and the existing TX share this package.
- One sub-module: uart_rx_sync, a 2-flop synchronizer plus edge-detect flop. It resets to 1, is parameterless, and is reusable for other async board inputs.

Test Plan:
- Loopback with top_print (BAUD_PER=10), rx_ready_i=1 -> each transmitted byte appears on rx_data_o with rx_valid_o high 1 cycle. Bytes match TX order; frame_err_o=0, overrun_o=0.
- Drive frame 0xA5 (bits LSB first 1,0,1,0,0,1,0,1), stop=1, BAUD_PER=10 -> rx_data_o=0xA5. rx_valid_o rises at D+96 and holds until rx_ready_i pulse.
- Low glitch of 3 cycles on idle line -> FSM returns to IDLE at START check; no valid, no frame_err.
- Frame 0x3C with stop bit driven 0 -> frame_err_o single-cycle pulse at the stop sample; rx_valid_o stays 0. The next good frame 0x5A is received.
- Overrun and clear:
  - Send 0x11 then 0x22 with rx_ready_i=0 -> rx_data_o=0x11 held, overrun_o=1.
  - Pulse err_clr_i -> overrun_o=0.
  - Set rx_ready_i=1 coincident with completion of 0x33 -> rx_data_o=0x33, no overrun.
- Assert nrst_i low during DATA bit 4 of 0xFF -> all outputs 0 immediately. Release, send 0x81 -> rx_data_o=0x81.
